// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared display geometry constants and arbiter state encoding
package seven_seg_pkg;
    localparam int DIGITS_PER_DISPLAY = 4;
    localparam int NIBBLE_WIDTH = 4;
    localparam int DISPLAY_WIDTH = DIGITS_PER_DISPLAY * NIBBLE_WIDTH;
    localparam logic [DISPLAY_WIDTH-1:0] BLANK_DIGITS = 16'h0000;
    typedef enum logic {IDLE, OWNED} arb_state_e;
endpackage

// File: rtl/rr_next_select.sv
// rr_next_select: first set bit of req searching upward from start, wrapping
module rr_next_select #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          valid
);
    int p;
    // scan from the far end so the candidate closest to start is written last
    always_comb begin
        grant = '0;
        valid = 1'b0;
        p = 0;
        for (int k = N - 1; k >= 0; k--) begin
            p = (int'(start) + k) % N;
            if (req[p]) begin
                grant = '0;
                grant[p] = 1'b1;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seven_seg_display_arbiter.sv
// seven_seg_display_arbiter: round-robin display sharing with dwell time; optional SEVEN_SEG_PRIORITY_OVERRIDE_EN
module seven_seg_display_arbiter
    import seven_seg_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int DWELL_WIDTH = 26
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_SOURCES-1:0]                    req,
    input  logic [DISPLAY_WIDTH*NUM_SOURCES-1:0]      src_digits,
    input  logic [DIGITS_PER_DISPLAY*NUM_SOURCES-1:0] src_dps,
    output logic [NUM_SOURCES-1:0]                    grant,
    output logic [DISPLAY_WIDTH-1:0]                  digits,
    output logic [DIGITS_PER_DISPLAY-1:0]             decimal_points,
    output logic                                      blank
);
    localparam int IW = $clog2(NUM_SOURCES);
    localparam logic [IW-1:0] LAST_SRC = IW'(NUM_SOURCES - 1);
    localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_WIDTH'(DWELL_CYCLES - 1);

    arb_state_e state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, last_q, last_d, sel_start, sel_idx;
    logic [DWELL_WIDTH-1:0] timer_q, timer_d;
    logic [NUM_SOURCES-1:0] grant_q, grant_d, sel_mask, sel_grant;
    logic [DISPLAY_WIDTH-1:0] digits_q, digits_d;
    logic [DIGITS_PER_DISPLAY-1:0] dps_q, dps_d;
    logic blank_q, blank_d, sel_valid, expire, preempt, rotate;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == LAST_SRC) ? '0 : x + 1'b1;
    endfunction

    // candidates exclude the current owner; search begins after last owner (idle) or current owner
    always_comb begin
        sel_mask = req & ~grant_q;
        sel_start = wrap_inc((state_q == IDLE) ? last_q : owner_q);
    end

    rr_next_select #(.N(NUM_SOURCES), .IW(IW)) u_sel (
        .req   (sel_mask),
        .start (sel_start),
        .grant (sel_grant),
        .valid (sel_valid)
    );

    // one-hot selection to source index
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            if (sel_grant[i]) sel_idx = IW'(i);
    end

    // ownership, dwell timer and the display image that follows the next owner
    always_comb begin
        expire = timer_q == DWELL_LAST;
`ifdef SEVEN_SEG_PRIORITY_OVERRIDE_EN
        preempt = (state_q == OWNED) && req[0] && (owner_q != '0);
        rotate = expire && sel_valid && (owner_q != '0);
`else
        preempt = 1'b0;
        rotate = expire && sel_valid;
`endif
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        timer_d = timer_q;
        if (state_q == IDLE) begin
            if (sel_valid) begin
                state_d = OWNED;
                owner_d = sel_idx;
                timer_d = '0;
            end
        end else if (preempt) begin
            owner_d = '0;
            last_d = owner_q;
            timer_d = '0;
        end else if (!req[owner_q] || rotate) begin
            last_d = owner_q;
            timer_d = '0;
            owner_d = sel_idx;
            state_d = sel_valid ? OWNED : IDLE;
        end else begin
            timer_d = expire ? '0 : timer_q + 1'b1;
        end
        grant_d = (state_d == OWNED) ? NUM_SOURCES'(1) << owner_d : '0;
        digits_d = (state_d == OWNED) ? src_digits[owner_d*DISPLAY_WIDTH +: DISPLAY_WIDTH] : BLANK_DIGITS;
        dps_d = (state_d == OWNED) ? src_dps[owner_d*DIGITS_PER_DISPLAY +: DIGITS_PER_DISPLAY] : '0;
        blank_d = state_d == IDLE;
    end

    // arbiter state and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q <= LAST_SRC;
            timer_q <= '0;
            grant_q <= '0;
            digits_q <= BLANK_DIGITS;
            dps_q <= '0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            digits_q <= digits_d;
            dps_q <= dps_d;
            blank_q <= blank_d;
        end
    end

    assign grant = grant_q;
    assign digits = digits_q;
    assign decimal_points = dps_q;
    assign blank = blank_q;
endmodule
